// File: rtl/audio_read_ctrl.sv
// Codec FIFO read sequencer with per-frame peak/loudness tracking.
// Build with AUDIO_STEREO_PEAK_EN defined to fold both channels into the peak.
module audio_read_ctrl #(
  parameter logic [23:0] THRESH_LO = 24'h00FFFF,
  parameter logic [23:0] THRESH_HI = 24'h3FFFFF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             read_ready,
  input  logic [23:0]      left_in,
  input  logic [23:0]      right_in,
  input  logic             frame_tick,
  output logic             read,
  output logic             sample_valid,
  output logic [23:0]      sample_left,
  output logic [23:0]      sample_right,
  output logic [23:0]      peak,
  output logic [1:0]       level,
  output logic             peak_valid,
  output logic [CNT_W-1:0] sample_count,
  output logic             stale
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t            state;
  logic              read_q;
  logic [23:0]       acc, acc_next, fold;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [1:0]        level_next;

  function automatic logic [23:0] mag(input logic [23:0] s);
    if (!s[23])              return s;
    else if (s == 24'h800000) return 24'h7FFFFF;
    else                     return -s;
  endfunction

  // Reset must suppress a pop already registered for this cycle.
  assign read = read_q & ~reset;

`ifdef AUDIO_STEREO_PEAK_EN
  logic [23:0] mag_l, mag_r;
  assign mag_l = mag(sample_left);
  assign mag_r = mag(sample_right);
  assign fold  = (mag_l > mag_r) ? mag_l : mag_r;
`else
  assign fold  = mag(sample_left);
`endif

  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (state == POP) begin
      if (fold > acc) acc_next = fold;
      if (cnt != '1)  cnt_next = cnt + 1'b1;
    end
    level_next = 2'd0;
    if (acc_next >= THRESH_HI)      level_next = 2'd2;
    else if (acc_next >= THRESH_LO) level_next = 2'd1;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state        <= IDLE;
      read_q       <= 1'b0;
      sample_valid <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      peak         <= '0;
      level        <= '0;
      peak_valid   <= 1'b0;
      sample_count <= '0;
      stale        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && read_ready) begin
            sample_left  <= left_in;
            sample_right <= right_in;
            read_q       <= 1'b1;
            sample_valid <= 1'b1;
            state        <= POP;
          end
        end
        POP: begin
          read_q       <= 1'b0;
          sample_valid <= 1'b0;
          state        <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // The sample folded in a tick cycle belongs to the frame being closed.
      if (frame_tick) begin
        peak         <= acc_next;
        level        <= level_next;
        sample_count <= cnt_next;
        stale        <= (cnt_next == '0);
        peak_valid   <= 1'b1;
        acc          <= '0;
        cnt          <= '0;
      end else begin
        peak_valid   <= 1'b0;
        acc          <= acc_next;
        cnt          <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_read_ctrl.sv
// Directed + randomized bench for audio_read_ctrl with a queue-based FIFO and frame model.
module tb_audio_read_ctrl;

  localparam int TLO = 32'h00FFFF;
  localparam int THI = 32'h3FFFFF;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b1, enable = 1'b1, read_ready = 1'b0, frame_tick = 1'b0;
  logic [23:0] left_in = '0, right_in = '0;
  logic        read, sample_valid, peak_valid, stale;
  logic [23:0] sample_left, sample_right, peak;
  logic [1:0]  level;
  logic [15:0] sample_count;

  audio_read_ctrl dut (
    .clk_50(clk_50), .reset(reset), .enable(enable), .read_ready(read_ready),
    .left_in(left_in), .right_in(right_in), .frame_tick(frame_tick),
    .read(read), .sample_valid(sample_valid), .sample_left(sample_left),
    .sample_right(sample_right), .peak(peak), .level(level), .peak_valid(peak_valid),
    .sample_count(sample_count), .stale(stale)
  );

  always #10 clk_50 = ~clk_50;

  int n_cmp = 0, n_err = 0;
  bit use_fifo = 1'b0;
  logic [23:0] q_l[$], q_r[$];
  int frame_max = 0, frame_n = 0;

  function automatic int amag(input logic [23:0] s);
    int v;
    v = int'(signed'(s));
    if (v < 0) v = -v;
    if (v > 32'h7FFFFF) v = 32'h7FFFFF;
    return v;
  endfunction

  function automatic int smag(input logic [23:0] l, input logic [23:0] r);
`ifdef AUDIO_STEREO_PEAK_EN
    return (amag(l) > amag(r)) ? amag(l) : amag(r);
`else
    return amag(l);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: react to pops seen on the falling edge, present the new head.
  task automatic service();
    if (use_fifo) begin
      if (sample_valid === 1'b1) begin
        n_cmp++;
        assert (q_l.size() > 0 && sample_left === q_l[0] && sample_right === q_r[0]) else begin
          n_err++;
          $error("FAIL sample_capture: observed %0h/%0h expected head of %0d-entry fifo",
                 sample_left, sample_right, q_l.size());
        end
      end
      if (read === 1'b1 && q_l.size() > 0) begin
        if (smag(q_l[0], q_r[0]) > frame_max) frame_max = smag(q_l[0], q_r[0]);
        frame_n++;
        void'(q_l.pop_front());
        void'(q_r.pop_front());
      end
      read_ready = (q_l.size() > 0);
      left_in    = (q_l.size() > 0) ? q_l[0] : 24'h0;
      right_in   = (q_r.size() > 0) ? q_r[0] : 24'h0;
    end
  endtask

  task automatic cyc();
    @(negedge clk_50);
    service();
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    q_l.push_back(l);
    q_r.push_back(r);
    read_ready = 1'b1;
    left_in    = q_l[0];
    right_in   = q_r[0];
  endtask

  task automatic drain(input bit rnd_en);
    int idle, budget;
    idle = 0; budget = 0;
    while (idle < 4 && budget < 600) begin
      if (rnd_en) enable = ($urandom % 4) != 0;
      cyc();
      budget++;
      if (q_l.size() == 0 && read !== 1'b1) idle++; else idle = 0;
    end
    enable = 1'b1;
    check("drain_budget", {31'b0, budget < 600}, 32'd1);
  endtask

  task automatic check_pub(input string tag, input int ep, input int en);
    int lv;
    lv = (ep >= THI) ? 2 : (ep >= TLO) ? 1 : 0;
    check({tag, "_pv"},    {31'b0, peak_valid}, 32'd1);
    check({tag, "_peak"},  {8'b0, peak}, ep);
    check({tag, "_level"}, {30'b0, level}, lv);
    check({tag, "_cnt"},   {16'b0, sample_count}, (en > 65535) ? 65535 : en);
    check({tag, "_stale"}, {31'b0, stale}, {31'b0, en == 0});
  endtask

  // Caller is at a falling edge; the tick is sampled on the next rising edge.
  task automatic pulse_tick(input string tag);
    int ep, en;
    ep = frame_max; en = frame_n; frame_max = 0; frame_n = 0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check_pub(tag, ep, en);
    cyc();
    check({tag, "_pv_once"}, {31'b0, peak_valid}, 32'd0);
  endtask

  initial begin
    int ep, en, nrd;
    bit hit;
    logic [23:0] ext[7];
    logic [23:0] l, r;
    ext = '{24'h800000, 24'h7FFFFF, 24'h400000, 24'h3FFFFF, 24'h00FFFF, 24'h010000, 24'hFFFFFF};

    // Reset holds everything low even with data waiting.
    read_ready = 1'b1;
    repeat (3) @(negedge clk_50);
    check("rst_read",  {31'b0, read}, 32'd0);
    check("rst_sv",    {31'b0, sample_valid}, 32'd0);
    check("rst_peak",  {8'b0, peak}, 32'd0);
    check("rst_level", {30'b0, level}, 32'd0);
    check("rst_cnt",   {16'b0, sample_count}, 32'd0);
    check("rst_stale", {31'b0, stale}, 32'd0);
    check("rst_pv",    {31'b0, peak_valid}, 32'd0);

    // Continuous read_ready: one pulse every third cycle, first one a cycle after release.
    reset = 1'b0;
    nrd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_50);
      check($sformatf("rd_pat%0d", i), {31'b0, read}, {31'b0, (i % 3) == 0});
      if (read === 1'b1) nrd++;
    end
    read_ready = 1'b0;
    frame_n = nrd;
    check("rd_total", nrd, 10);
    use_fifo = 1'b1;
    drain(1'b0);
    pulse_tick("t1");

    // Mixed-sign left samples.
    push(24'h000100, 24'h0); push(24'hFF0000, 24'h0); push(24'h001000, 24'h0);
    drain(1'b0);
    pulse_tick("t2");

    // Most negative value saturates; an empty frame follows.
    push(24'h800000, 24'h000001);
    drain(1'b0);
    pulse_tick("t3a");
    pulse_tick("t3b");

    // Sample folded on the tick edge belongs to the closing frame.
    push(24'h400000, 24'h0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_50);
      hit = (read === 1'b1);
      service();
    end
    check("t4_hit", {31'b0, hit}, 32'd1);
    pulse_tick("t4a");
    drain(1'b0);
    pulse_tick("t4b");

    // Back-to-back ticks.
    push(24'h000200, 24'h0);
    drain(1'b0);
    ep = frame_max; en = frame_n; frame_max = 0; frame_n = 0;
    frame_tick = 1'b1;
    cyc();
    check_pub("b2b1", ep, en);
    cyc();
    frame_tick = 1'b0;
    check_pub("b2b2", 0, 0);

    // Reset landing on a pop cycle.
    push(24'h123456, 24'h654321);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_50);
      hit = (read === 1'b1);
      if (!hit) service();
    end
    check("rp_hit", {31'b0, hit}, 32'd1);
    reset = 1'b1;
    #1;
    check("rp_read_gated", {31'b0, read}, 32'd0);
    frame_max = 0; frame_n = 0;
    cyc();
    check("rp_read",  {31'b0, read}, 32'd0);
    check("rp_sv",    {31'b0, sample_valid}, 32'd0);
    check("rp_left",  {8'b0, sample_left}, 32'd0);
    check("rp_right", {8'b0, sample_right}, 32'd0);
    check("rp_peak",  {8'b0, peak}, 32'd0);
    check("rp_cnt",   {16'b0, sample_count}, 32'd0);
    check("rp_stale", {31'b0, stale}, 32'd0);
    cyc();
    check("rp_hold", {31'b0, read}, 32'd0);
    reset = 1'b0;
    drain(1'b0);
    check("rp_fifo_empty", q_l.size(), 0);
    pulse_tick("rp");

    // Stereo fold (model chooses per build).
    push(24'h000010, 24'hC00000);
    drain(1'b0);
    pulse_tick("st");

    // Random frames with enable jitter.
    for (int f = 0; f < 8; f++) begin
      for (int k = $urandom_range(0, 6); k > 0; k--) begin
        l = ($urandom % 4 == 0) ? ext[$urandom_range(0, 6)] : 24'($urandom);
        r = ($urandom % 4 == 0) ? ext[$urandom_range(0, 6)] : 24'($urandom);
        push(l, r);
      end
      drain(1'b1);
      pulse_tick($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
